// File: rtl/npu_conv_seq.sv
// Autonomous output-position sequencer for the KxK convolution datapath.
// Optional ReLU clamp on the captured result: define NPU_CONV_SEQ_RELU_EN.
module npu_conv_seq #(
  parameter int unsigned K_H  = 3,
  parameter int unsigned K_W  = 3,
  parameter int unsigned IN_H = 16,
  parameter int unsigned IN_W = 15,
  parameter int unsigned AW   = 8
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             relu_i,
  output logic             mem_re_o,
  output logic [AW-1:0]    mem_addr_o,
  input  logic [8*K_H-1:0] mem_rdata_i,
  output logic [8*K_H-1:0] col_data_o,
  output logic             col_load_o,
  output logic             pe_clear_o,
  output logic             pe_trig_o,
  output logic             pe_minus_o,
  output logic             w_shift_o,
  input  logic [23:0]      pe_sum_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [23:0]      out_data_o,
  output logic [4:0]       out_row_o,
  output logic [4:0]       out_col_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned OUT_H = IN_H - K_H + 1;
  localparam int unsigned OUT_W = IN_W - K_W + 1;
  localparam int unsigned JW    = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int unsigned CW    = 5;
  localparam int unsigned DW    = 24;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_LOAD, S_CAL, S_MINUS, S_SETTLE, S_EMIT
  } state_e;

  state_e          state_q;
  logic [JW-1:0]   j_q;
  logic [CW-1:0]   r_q;
  logic [CW-1:0]   c_q;
  logic [AW-1:0]   row_base_q;

  logic            last_j;
  logic            last_col;
  logic            last_row;
  logic [AW-1:0]   addr_first_d;
  logic [AW-1:0]   addr_next_d;
  logic [DW-1:0]   sum_d;

  assign last_j       = (j_q == JW'(K_W - 1));
  assign last_col     = (c_q == CW'(OUT_W - 1));
  assign last_row     = (r_q == CW'(OUT_H - 1));
  assign addr_first_d = row_base_q + AW'(c_q);
  assign addr_next_d  = addr_first_d + AW'(j_q) + AW'(1);

  // Read data arrives in LOAD; forward it only while the load strobe is up.
  assign col_data_o = (state_q == S_LOAD) ? mem_rdata_i : '0;

`ifdef NPU_CONV_SEQ_RELU_EN
  assign sum_d = (relu_i && pe_sum_i[DW-1]) ? '0 : pe_sum_i;
`else
  logic unused_relu;
  assign unused_relu = relu_i;
  assign sum_d       = pe_sum_i;
`endif

  // Strobes are set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      row_base_q  <= '0;
      mem_re_o    <= 1'b0;
      mem_addr_o  <= '0;
      col_load_o  <= 1'b0;
      pe_clear_o  <= 1'b0;
      pe_trig_o   <= 1'b0;
      pe_minus_o  <= 1'b0;
      w_shift_o   <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_row_o   <= '0;
      out_col_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      mem_re_o   <= 1'b0;
      col_load_o <= 1'b0;
      pe_clear_o <= 1'b0;
      pe_trig_o  <= 1'b0;
      pe_minus_o <= 1'b0;
      w_shift_o  <= 1'b0;
      if (abort_i) begin
        state_q     <= S_IDLE;
        out_valid_o <= 1'b0;
        busy_o      <= 1'b0;
        j_q         <= '0;
        r_q         <= '0;
        c_q         <= '0;
        row_base_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_q    <= S_CLR;
              done_o     <= 1'b0;
              busy_o     <= 1'b1;
              pe_clear_o <= 1'b1;
            end
          end
          S_CLR: begin
            state_q    <= S_FETCH;
            j_q        <= '0;
            mem_re_o   <= 1'b1;
            mem_addr_o <= addr_first_d;
          end
          S_FETCH: begin
            state_q    <= S_LOAD;
            col_load_o <= 1'b1;
          end
          S_LOAD: begin
            state_q   <= S_CAL;
            pe_trig_o <= 1'b1;
          end
          S_CAL: begin
            state_q    <= S_MINUS;
            pe_minus_o <= 1'b1;
            w_shift_o  <= 1'b1;
          end
          S_MINUS: begin
            if (last_j) begin
              state_q <= S_SETTLE;
            end else begin
              state_q    <= S_FETCH;
              j_q        <= j_q + JW'(1);
              mem_re_o   <= 1'b1;
              mem_addr_o <= addr_next_d;
            end
          end
          S_SETTLE: begin
            state_q     <= S_EMIT;
            out_data_o  <= sum_d;
            out_row_o   <= r_q;
            out_col_o   <= c_q;
            out_valid_o <= 1'b1;
          end
          S_EMIT: begin
            // Hold result and coordinates until the downstream accepts.
            if (out_ready_i) begin
              out_valid_o <= 1'b0;
              if (last_col && last_row) begin
                state_q    <= S_IDLE;
                done_o     <= 1'b1;
                busy_o     <= 1'b0;
                r_q        <= '0;
                c_q        <= '0;
                row_base_q <= '0;
              end else begin
                state_q    <= S_CLR;
                pe_clear_o <= 1'b1;
                if (last_col) begin
                  c_q        <= '0;
                  r_q        <= r_q + CW'(1);
                  row_base_q <= row_base_q + AW'(IN_W);
                end else begin
                  c_q <= c_q + CW'(1);
                end
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_conv_seq.sv
// Bench for npu_conv_seq: image buffer and ternary-weight PE models, direct convolution reference.
module tb_npu_conv_seq;

  localparam int IN_H = 16;
  localparam int IN_W = 15;
  localparam int OUT_H = 14;
  localparam int OUT_W = 13;
  localparam int NPIX = OUT_H * OUT_W;
  localparam int AW = 8;

  localparam int W_TRIG = 0, W_VALID = 1, W_DONE = 2, W_MINUS = 3, W_MEMRE = 4, W_CLEAR = 5;

  logic clk, rst_ni, start_i, abort_i, relu_i, out_ready_i;
  logic mem_re_o, col_load_o, pe_clear_o, pe_trig_o, pe_minus_o, w_shift_o;
  logic out_valid_o, busy_o, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [23:0] mem_rdata_i, col_data_o, pe_sum_i, out_data_o;
  logic [4:0] out_row_o, out_col_o;

  npu_conv_seq dut (
    .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i), .relu_i(relu_i),
    .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .col_data_o(col_data_o), .col_load_o(col_load_o), .pe_clear_o(pe_clear_o),
    .pe_trig_o(pe_trig_o), .pe_minus_o(pe_minus_o), .w_shift_o(w_shift_o),
    .pe_sum_i(pe_sum_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_row_o(out_row_o), .out_col_o(out_col_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] img [IN_H][IN_W];
  int w [3][3];
  int n_vec = 0;
  int n_err = 0;

  // Environment: registered column-word buffer and ternary PE column.
  function automatic logic [23:0] mem_word(logic [AW-1:0] a);
    int r = int'(a) / IN_W;
    int c = int'(a) % IN_W;
    logic [23:0] wd = '0;
    for (int i = 0; i < 3; i++) if (r + i < IN_H) wd[8*i +: 8] = img[r+i][c];
    return wd;
  endfunction

  function automatic int pe_part(logic [23:0] col, int p, int sgn);
    int s = 0;
    for (int i = 0; i < 3; i++) if (w[i][p] == sgn) s += int'(col[8*i +: 8]);
    return s;
  endfunction

  logic [23:0] colreg = '0;
  logic [23:0] acc = '0;
  int ptr = 0;
  bit pe_resync = 1'b1;

  always @(posedge clk) begin
    if (mem_re_o) mem_rdata_i <= mem_word(mem_addr_o);
    if (pe_resync) ptr <= 0;
    else if (w_shift_o) ptr <= (ptr == 2) ? 0 : ptr + 1;
    if (col_load_o) colreg <= col_data_o;
    if (pe_clear_o) acc <= '0;
    else if (pe_trig_o) acc <= acc + 24'(pe_part(colreg, ptr, 1));
    else if (pe_minus_o) acc <= acc - 24'(pe_part(colreg, ptr, -1));
  end
  assign pe_sum_i = acc;

  // Transaction logs
  logic [33:0] res_q[$];
  logic [AW-1:0] addr_q[$];
  int n_shift = 0;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (mem_re_o) addr_q.push_back(mem_addr_o);
      if (w_shift_o) n_shift++;
      if (out_valid_o && out_ready_i) res_q.push_back({out_row_o, out_col_o, out_data_o});
    end
  end

  function automatic logic [23:0] ref_pix(int r, int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += int'(img[r+i][c+j]) * w[i][j];
`ifdef NPU_CONV_SEQ_RELU_EN
    if (relu_i && s < 0) s = 0;
`endif
    return 24'(s);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cond(int what);
    case (what)
      W_TRIG:  return pe_trig_o;
      W_VALID: return out_valid_o;
      W_DONE:  return done_o;
      W_MINUS: return pe_minus_o;
      W_MEMRE: return mem_re_o;
      W_CLEAR: return pe_clear_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int what, input int budget, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(what) && n < budget);
    if (!cond(what)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  task automatic fill_img(input int v);
    for (int i = 0; i < IN_H; i++) for (int j = 0; j < IN_W; j++) img[i][j] = 8'(v);
  endtask

  task automatic set_w(input int npos, input int nneg);
    for (int k = 0; k < 9; k++)
      w[k/3][k%3] = (k < npos) ? 1 : (k < npos + nneg) ? -1 : 0;
  endtask

  task automatic clear_logs();
    res_q.delete();
    addr_q.delete();
    n_shift = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    pe_resync = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    pe_resync = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input int n);
    chk("result_count", 64'(res_q.size()), 64'(n));
    for (int k = 0; k < n && k < res_q.size(); k++)
      chk($sformatf("pix_%0d_%0d", k / OUT_W, k % OUT_W), 64'(res_q[k]),
          64'({5'(k / OUT_W), 5'(k % OUT_W), ref_pix(k / OUT_W, k % OUT_W)}));
  endtask

  typedef struct { int pix; int npos; int nneg; bit relu; int exp_off; int exp_on; } dvec_t;
  typedef struct { int r; int c; int a0; } avec_t;
  dvec_t tv[7];
  avec_t ta[5];

  initial begin
    int n, t0, idx;
    logic [23:0] exp_d;
    tv[0] = '{1,   9, 0, 1'b0, 9,     9};
    tv[1] = '{1,   2, 7, 1'b1, -5,    0};
    tv[2] = '{1,   2, 7, 1'b0, -5,    -5};
    tv[3] = '{255, 9, 0, 1'b0, 2295,  2295};
    tv[4] = '{200, 0, 9, 1'b1, -1800, 0};
    tv[5] = '{7,   4, 4, 1'b1, 0,     0};
    tv[6] = '{0,   9, 0, 1'b0, 0,     0};
    ta[0] = '{0, 0, 0};
    ta[1] = '{0, 1, 1};
    ta[2] = '{1, 0, 15};
    ta[3] = '{13, 12, 207};
    ta[4] = '{5, 7, 82};

    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; relu_i = 1'b0; out_ready_i = 1'b1;
    fill_img(1);
    set_w(9, 0);
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("reset_flags", 64'({mem_re_o, col_load_o, pe_clear_o, pe_trig_o, pe_minus_o,
                            w_shift_o, out_valid_o, busy_o, done_o}), 64'(0));
    chk("reset_addr", 64'(mem_addr_o), 64'(0));
    chk("reset_data", 64'({out_data_o, out_row_o, out_col_o}), 64'(0));

    // First-pixel datapath vectors, each run aborted after its first result
    for (int t = 0; t < 7; t++) begin
      fill_img(tv[t].pix);
      set_w(tv[t].npos, tv[t].nneg);
      relu_i = tv[t].relu;
      pulse_start();
      wait_for(W_VALID, 100, "tv_valid", n);
`ifdef NPU_CONV_SEQ_RELU_EN
      exp_d = 24'(tv[t].exp_on);
`else
      exp_d = 24'(tv[t].exp_off);
`endif
      chk($sformatf("tv%0d_data", t), 64'(out_data_o), 64'(exp_d));
      chk($sformatf("tv%0d_coord", t), 64'({out_row_o, out_col_o}), 64'(0));
      do_abort();
    end
    relu_i = 1'b0;

    // Reset asserted mid-CAL
    fill_img(1);
    set_w(9, 0);
    pulse_start();
    wait_for(W_TRIG, 50, "t1_cal", n);
    rst_ni = 1'b0;
    #1;
    chk("t1_flags", 64'({mem_re_o, col_load_o, pe_clear_o, pe_trig_o, pe_minus_o,
                         w_shift_o, out_valid_o, busy_o, done_o}), 64'(0));
    chk("t1_bus", 64'({mem_addr_o, col_data_o, out_data_o, out_row_o, out_col_o}), 64'(0));
    pe_resync = 1'b1;
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("t1_busy_after", 64'(busy_o), 64'(0));

    // Full frame, all-ones image and weights, no backpressure
    clear_logs();
    pulse_start();
    wait_for(W_CLEAR, 5, "t2_clr", n);
    wait_for(W_DONE, 4000, "t2_done", t0);
    chk("t2_done_latency", 64'(t0), 64'(NPIX * 15));
    chk("t2_done_busy", 64'({done_o, busy_o}), 64'(2'b10));
    chk("t3_shift_count", 64'(n_shift), 64'(NPIX * 3));
    chk("t2_addr_count", 64'(addr_q.size()), 64'(NPIX * 3));
    check_frame(NPIX);
    for (int t = 0; t < 5; t++)
      for (int j = 0; j < 3; j++) begin
        idx = (ta[t].r * OUT_W + ta[t].c) * 3 + j;
        if (idx < addr_q.size())
          chk($sformatf("addr_%0d_%0d_j%0d", ta[t].r, ta[t].c, j), 64'(addr_q[idx]), 64'(ta[t].a0 + j));
        else
          chk("addr_missing", 64'(addr_q.size()), 64'(idx + 1));
      end

    // Backpressure at pixel (0,0)
    clear_logs();
    @(posedge clk); #1 out_ready_i = 1'b0;
    pulse_start();
    wait_for(W_VALID, 100, "t4_valid", n);
    chk("t4_start_clears_done", 64'(done_o), 64'(0));
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold", 64'({out_valid_o, out_data_o, out_row_o, out_col_o}), 64'({1'b1, 24'd9, 10'd0}));
      chk("t4_quiet", 64'({mem_re_o, col_load_o, pe_clear_o, pe_trig_o, pe_minus_o, w_shift_o}), 64'(0));
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready_i = 1'b1;
    wait_for(W_MEMRE, 40, "t4_resume", n);
    chk("t4_resume_addr", 64'(mem_addr_o), 64'(1));
    chk("t4_res_count", 64'(res_q.size()), 64'(1));
    do_abort();

    // Abort in MINUS of pixel (2,4); mid-run start ignored
    clear_logs();
    pulse_start();
    repeat (20) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    n = 0;
    while (res_q.size() < 30 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_pixel", 64'(res_q.size() >= 30), 64'(1));
    wait_for(W_MINUS, 20, "t5_minus", n);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("t5_abort_idle", 64'({busy_o, out_valid_o, done_o, mem_re_o, pe_clear_o, pe_trig_o, pe_minus_o}), 64'(0));
    check_frame(30);
    pe_resync = 1'b1;

    // Restart from address 0 with random image/weights and random backpressure
    clear_logs();
    for (int i = 0; i < IN_H; i++) for (int j = 0; j < IN_W; j++) img[i][j] = 8'($urandom);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) w[i][j] = int'($urandom_range(2)) - 1;
    relu_i = 1'($urandom_range(1));
    pulse_start();
    wait_for(W_MEMRE, 10, "t5_restart", n);
    chk("t5_restart_addr", 64'(mem_addr_o), 64'(0));
    n = 0;
    while (!done_o && n < 12000) begin
      @(posedge clk); #1 out_ready_i = ($urandom_range(3) != 0);
      n++;
    end
    out_ready_i = 1'b1;
    chk("rand_done", 64'(done_o), 64'(1));
    check_frame(NPIX);
    chk("rand_shift_count", 64'(n_shift), 64'(NPIX * 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
